id_stage: RTL and testbench

Instruction decode stage sitting directly downstream of the instruction fetch unit. It captures the fetched 32-bit MIPS instruction into an IF/ID register, decodes it into datapath control, reads two operands from an internal 32×32 register file with write-back bypass, and returns `jump`/`branch` to the fetch unit. It supports stall and flush from the hazard/branch logic.

---
 rtl/id_pkg.sv | 59 +++++
 rtl/regfile.sv | 54 +++++
 rtl/id_stage.sv | 150 +++++++++++++++
 tb/tb_id_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode constants for the instruction decode stage: MIPS opcode/funct
// values, the ALU operation encoding and the bundled control word.
package id_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;
   localparam logic [5:0] FN_SLL = 6'h00;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4,
      ALU_SLL = 3'd5,
      ALU_LUI = 3'd6
   } alu_op_e;

   typedef enum logic [1:0] {
      IMM_SIGN  = 2'd0,
      IMM_ZERO  = 2'd1,
      IMM_UPPER = 2'd2
   } imm_sel_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    alu_src;
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    branch;
      logic    jump;
      logic    illegal;
   } ctrl_t;

   function automatic logic [31:0] extend_imm(input logic [15:0] imm, input imm_sel_e sel);
      logic [31:0] ext;
      case (sel)
         IMM_ZERO:  ext = {16'h0000, imm};
         IMM_UPPER: ext = {imm, 16'h0000};
         default:   ext = {{16{imm[15]}}, imm};
      endcase
      return ext;
   endfunction

endpackage

// File: rtl/regfile.sv
// 2-read / 1-write register file with $0 tied to zero and same-cycle
// write-back bypass onto both read ports.
module regfile
   import id_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_NUM    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(REG_NUM)-1:0] rs_addr,
   input  logic [$clog2(REG_NUM)-1:0] rt_addr,
   input  logic                       wb_en,
   input  logic [$clog2(REG_NUM)-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0]      wb_data,
   output logic [DATA_WIDTH-1:0]      rs_data,
   output logic [DATA_WIDTH-1:0]      rt_data
);

   logic [DATA_WIDTH-1:0] mem [REG_NUM];
   logic                  wr_live;

   assign wr_live = wb_en && (wb_addr != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_live) begin
         mem[wb_addr] <= wb_data;
      end
   end

   // Bypass lets an instruction consume a result written back in the same cycle.
   always_comb begin
      rs_data = mem[rs_addr];
      if (rs_addr == '0) begin
         rs_data = '0;
      end else if (wr_live && (wb_addr == rs_addr)) begin
         rs_data = wb_data;
      end
   end

   always_comb begin
      rt_data = mem[rt_addr];
      if (rt_addr == '0) begin
         rt_data = '0;
      end else if (wr_live && (wb_addr == rt_addr)) begin
         rt_data = wb_data;
      end
   end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction decode stage: IF/ID register with stall/flush, control
// decode, immediate extension and operand read through the register file.
module id_stage
   import id_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_NUM    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                instruction,
   input  logic                       if_valid,
   input  logic                       stall,
   input  logic                       flush,
   input  logic                       wb_en,
   input  logic [$clog2(REG_NUM)-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0]      wb_data,
   output logic                       id_valid,
   output logic [DATA_WIDTH-1:0]      rs_data,
   output logic [DATA_WIDTH-1:0]      rt_data,
   output logic [31:0]                imm_ext,
   output logic [4:0]                 shamt,
   output logic [$clog2(REG_NUM)-1:0] dst_addr,
   output logic [25:0]                jump_target,
   output logic [2:0]                 alu_op,
   output logic                       alu_src,
   output logic                       reg_write,
   output logic                       mem_read,
   output logic                       mem_write,
   output logic                       mem_to_reg,
   output logic                       branch,
   output logic                       jump,
   output logic                       illegal
);

   // Handshake: if_valid qualifies `instruction` in the cycle it is sampled;
   // id_valid qualifies every decoded output for as long as instr_q holds it.
   // There is no ready; back-pressure is the stall input.
   logic [31:0] instr_q;
   logic        valid_q;
   ctrl_t       ctrl;
   imm_sel_e    imm_sel;
   logic [5:0]  op;
   logic [5:0]  funct;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         instr_q <= '0;
         valid_q <= 1'b0;
      end else if (!stall) begin
         instr_q <= instruction;
         valid_q <= if_valid;
      end
   end

   assign op    = instr_q[31:26];
   assign funct = instr_q[5:0];

   always_comb begin
      ctrl    = '0;
      imm_sel = IMM_SIGN;
      case (op)
         OP_RTYPE: begin
            ctrl.reg_write = 1'b1;
            case (funct)
               FN_ADD:  ctrl.alu_op = ALU_ADD;
               FN_SUB:  ctrl.alu_op = ALU_SUB;
               FN_AND:  ctrl.alu_op = ALU_AND;
               FN_OR:   ctrl.alu_op = ALU_OR;
               FN_SLT:  ctrl.alu_op = ALU_SLT;
               FN_SLL:  ctrl.alu_op = ALU_SLL;
               default: ctrl.illegal = 1'b1;
            endcase
         end
         OP_ADDI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OP_ORI: begin
            ctrl.alu_op    = ALU_OR;
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            imm_sel        = IMM_ZERO;
         end
         OP_LUI: begin
            ctrl.alu_op    = ALU_LUI;
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
            imm_sel        = IMM_UPPER;
         end
         OP_LW: begin
            ctrl.alu_src    = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         OP_BEQ: begin
            ctrl.alu_op = ALU_SUB;
            ctrl.branch = 1'b1;
         end
         OP_J:    ctrl.jump = 1'b1;
         default: ctrl.illegal = 1'b1;
      endcase

      // An unsupported encoding must not leak any partial control.
      if (ctrl.illegal) begin
         ctrl         = '0;
         ctrl.illegal = 1'b1;
      end
      // Empty slot (reset, flush, bubble) drives the idle control word.
      if (!valid_q) begin
         ctrl = '0;
      end
   end

   assign id_valid    = valid_q;
   assign alu_op      = ctrl.alu_op;
   assign alu_src     = ctrl.alu_src;
   assign reg_write   = ctrl.reg_write;
   assign mem_read    = ctrl.mem_read;
   assign mem_write   = ctrl.mem_write;
   assign mem_to_reg  = ctrl.mem_to_reg;
   assign branch      = ctrl.branch;
   assign jump        = ctrl.jump;
   assign illegal     = ctrl.illegal;
   assign imm_ext     = extend_imm(instr_q[15:0], imm_sel);
   assign shamt       = instr_q[10:6];
   assign jump_target = instr_q[25:0];
   assign dst_addr    = (op == OP_RTYPE) ? instr_q[15:11] : instr_q[20:16];

   regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_NUM    (REG_NUM)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .rs_addr (instr_q[25:21]),
      .rt_addr (instr_q[20:16]),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .rs_data (rs_data),
      .rt_data (rt_data)
   );

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-computed decode vectors, bypass, $0,
// stall/flush and reset-vs-write-back priority.
module tb_id_stage;

   logic        clk;
   logic        rst;
   logic [31:0] instruction;
   logic        if_valid;
   logic        stall;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        id_valid;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] imm_ext;
   logic [4:0]  shamt;
   logic [4:0]  dst_addr;
   logic [25:0] jump_target;
   logic [2:0]  alu_op;
   logic        alu_src;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;
   logic        branch;
   logic        jump;
   logic        illegal;

   int n_cmp;
   int n_err;
   logic [31:0] exp_q[$];

   id_stage dut (
      .clk         (clk),
      .rst         (rst),
      .instruction (instruction),
      .if_valid    (if_valid),
      .stall       (stall),
      .flush       (flush),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .id_valid    (id_valid),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .imm_ext     (imm_ext),
      .shamt       (shamt),
      .dst_addr    (dst_addr),
      .jump_target (jump_target),
      .alu_op      (alu_op),
      .alu_src     (alu_src),
      .reg_write   (reg_write),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_to_reg  (mem_to_reg),
      .branch      (branch),
      .jump        (jump),
      .illegal     (illegal)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  alu;
      logic [31:0] imm;
      logic [4:0]  dst;
      logic [7:0]  flags;  // {alu_src,reg_write,mem_read,mem_write,mem_to_reg,branch,jump,illegal}
   } vec_t;

   vec_t vecs[14];

   function automatic logic [7:0] flags_now();
      return {alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, jump, illegal};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic v);
      instruction = ins;
      if_valid    = v;
   endtask

   task automatic drive_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
      wb_en   = en;
      wb_addr = a;
      wb_data = d;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      vecs[0]  = '{32'h20010005, 3'd0, 32'h00000005, 5'd1, 8'hC0};  // addi $1,$0,5
      vecs[1]  = '{32'h1022FFFF, 3'd1, 32'hFFFFFFFF, 5'd2, 8'h04};  // beq $1,$2,-1
      vecs[2]  = '{32'h3403FFFF, 3'd3, 32'h0000FFFF, 5'd3, 8'hC0};  // ori $3,$0,0xFFFF
      vecs[3]  = '{32'h3C041234, 3'd6, 32'h12340000, 5'd4, 8'hC0};  // lui $4,0x1234
      vecs[4]  = '{32'h8C250008, 3'd0, 32'h00000008, 5'd5, 8'hE8};  // lw $5,8($1)
      vecs[5]  = '{32'hAC25FFFC, 3'd0, 32'hFFFFFFFC, 5'd5, 8'h90};  // sw $5,-4($1)
      vecs[6]  = '{32'h00223022, 3'd1, 32'h00003022, 5'd6, 8'h40};  // sub $6,$1,$2
      vecs[7]  = '{32'h00224024, 3'd2, 32'h00004024, 5'd8, 8'h40};  // and $8,$1,$2
      vecs[8]  = '{32'h00224825, 3'd3, 32'h00004825, 5'd9, 8'h40};  // or $9,$1,$2
      vecs[9]  = '{32'h0022382A, 3'd4, 32'h0000382A, 5'd7, 8'h40};  // slt $7,$1,$2
      vecs[10] = '{32'h000240C0, 3'd5, 32'h000040C0, 5'd8, 8'h40};  // sll $8,$2,3
      vecs[11] = '{32'h00221021, 3'd0, 32'h00001021, 5'd2, 8'h01};  // bad funct 0x21
      vecs[12] = '{32'hFC000000, 3'd0, 32'h00000000, 5'd0, 8'h01};  // opcode 0x3F
      vecs[13] = '{32'h08000040, 3'd0, 32'h00000040, 5'd0, 8'h02};  // j 0x40

      // Reset held 2 cycles, with flush and a write-back to $11 that must not land.
      rst = 1'b1; stall = 1'b0; flush = 1'b1;
      drive(32'h20010005, 1'b1);
      drive_wb(1'b1, 5'd11, 32'h00000055);
      tick();
      tick();
      rst = 1'b0; flush = 1'b0;
      drive_wb(1'b0, 5'd0, 32'h0);
      drive(32'h0, 1'b0);
      #1;
      check("rst_id_valid", {31'b0, id_valid}, 32'h0);
      check("rst_flags", {24'b0, flags_now()}, 32'h0);
      check("rst_alu_op", {29'b0, alu_op}, 32'h0);
      check("rst_rs_data", rs_data, 32'h0);
      check("rst_rt_data", rt_data, 32'h0);
      check("rst_imm", imm_ext, 32'h0);
      check("rst_dst", {27'b0, dst_addr}, 32'h0);
      check("rst_shamt", {27'b0, shamt}, 32'h0);
      check("rst_jt", {6'b0, jump_target}, 32'h0);

      // Decode table: each instruction visible one cycle after it is presented.
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].instr, 1'b1);
         tick();
         check($sformatf("v%0d_valid", i), {31'b0, id_valid}, 32'h1);
         check($sformatf("v%0d_alu", i), {29'b0, alu_op}, {29'b0, vecs[i].alu});
         check($sformatf("v%0d_imm", i), imm_ext, vecs[i].imm);
         check($sformatf("v%0d_dst", i), {27'b0, dst_addr}, {27'b0, vecs[i].dst});
         check($sformatf("v%0d_flags", i), {24'b0, flags_now()}, {24'b0, vecs[i].flags});
         if (i == 10) check("sll_shamt", {27'b0, shamt}, 32'd3);
         if (i == 13) check("j_target", {6'b0, jump_target}, 32'h0000040);
      end

      // Same illegal opcode without if_valid: slot is empty, nothing asserted.
      drive(32'hFC000000, 1'b0);
      tick();
      check("inv_illegal", {31'b0, illegal}, 32'h0);
      check("inv_id_valid", {31'b0, id_valid}, 32'h0);

      // $11 written only during reset must read back 0.
      drive(32'h01605020, 1'b1);  // add $10,$11,$0
      tick();
      check("rst_blocks_wb", rs_data, 32'h0);

      // Bypass: add $2,$1,$1 decoded while $1<=5 is on the write-back port.
      drive(32'h00211020, 1'b1);
      tick();
      check("pre_bypass_rs", rs_data, 32'h0);
      drive_wb(1'b1, 5'd1, 32'h5);
      #1;
      check("bypass_rs", rs_data, 32'h5);
      check("bypass_rt", rt_data, 32'h5);
      check("bypass_dst", {27'b0, dst_addr}, 32'd2);
      tick();
      drive_wb(1'b0, 5'd0, 32'h0);
      #1;
      check("stored_rs", rs_data, 32'h5);

      // $0 write attempt, with rs=rt=$0 decoded during the attempt.
      drive_wb(1'b1, 5'd0, 32'hDEADBEEF);
      drive(32'h00001820, 1'b1);  // add $3,$0,$0
      tick();
      check("zero_bypass_rs", rs_data, 32'h0);
      check("zero_bypass_rt", rt_data, 32'h0);
      tick();
      drive_wb(1'b0, 5'd0, 32'h0);
      #1;
      check("zero_stored", rs_data, 32'h0);

      // Stall: beq held 3 cycles while the fetch side keeps changing.
      drive(32'h1022FFFF, 1'b1);
      tick();
      check("beq_rs", rs_data, 32'h5);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back(32'hFFFFFFFF);
      for (int i = 0; i < 3; i++) begin
         drive(32'h08000040 + i, (i != 1));
         tick();
         check($sformatf("stall%0d_imm", i), imm_ext, exp_q.pop_front());
         check($sformatf("stall%0d_branch", i), {31'b0, branch}, 32'h1);
         check($sformatf("stall%0d_jump", i), {31'b0, jump}, 32'h0);
      end

      // Flush wins over stall; a write-back in the same cycle still commits.
      flush = 1'b1;
      drive_wb(1'b1, 5'd9, 32'h00000099);
      tick();
      flush = 1'b0;
      stall = 1'b0;
      drive_wb(1'b0, 5'd0, 32'h0);
      #1;
      check("flush_id_valid", {31'b0, id_valid}, 32'h0);
      check("flush_branch", {31'b0, branch}, 32'h0);
      check("flush_jump", {31'b0, jump}, 32'h0);
      check("flush_reg_write", {31'b0, reg_write}, 32'h0);
      drive(32'h01205020, 1'b1);  // add $10,$9,$0
      tick();
      check("flush_wb_commit", rs_data, 32'h00000099);
      check("after_flush_valid", {31'b0, id_valid}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
